// File: rtl/jump_key_pkg.sv
// jump_key_pkg
//   Shared types and constants for the jump-key debouncer.
//   key_state_e : debounce FSM states (3-bit encoding)
//   CNT_W       : width of the sample counter
//   CNT_MAX     : saturation value of the sample counter
package jump_key_pkg;

   localparam int            CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      PRESSED      = 3'd2,
      HELD         = 3'd3,
      RELEASE_WAIT = 3'd4
   } key_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Two-flop synchroniser for an asynchronous 1-bit input, optionally
//   followed by a rising-edge detector.
//   clk   : system clock
//   rst   : synchronous active-high reset (all flops clear to 0)
//   d_i   : asynchronous input
//   q_o   : EDGE=1 -> one-cycle pulse on a synchronised 0->1 transition
//           EDGE=0 -> synchronised level
module sync_edge_detect #(
   parameter bit EDGE = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   generate
      if (EDGE) begin : g_edge
         logic prev_q;

         always_ff @(posedge clk) begin
            if (rst) prev_q <= 1'b0;
            else     prev_q <= sync_q;
         end

         assign q_o = sync_q & ~prev_q;
      end else begin : g_level
         assign q_o = sync_q;
      end
   endgenerate

endmodule

// File: rtl/jump_key_debounce.sv
// jump_key_debounce
//   Debounces the jump push-button, sampling it on rising edges of the
//   divided clock (treated purely as data, never as a clock).
//   clk         : system clock
//   rst         : synchronous active-high reset
//   sample_clk  : divided square wave; each rising edge is one sample strobe
//   key_raw     : asynchronous button input (polarity set by ACTIVE_LOW)
//   key_level   : debounced state, 1 = pressed
//   key_press   : one-cycle pulse when a press is accepted
//   key_release : one-cycle pulse when a release is accepted
//   key_hold    : high once the key has been held HOLD_SAMPLES samples
//   Parameters: STABLE_SAMPLES (2..255), HOLD_SAMPLES (> STABLE_SAMPLES,
//   <= 255), ACTIVE_LOW.
module jump_key_debounce
   import jump_key_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = 4,
   parameter int unsigned HOLD_SAMPLES   = 16,
   parameter bit          ACTIVE_LOW     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_clk,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_hold
);

   localparam logic [CNT_W:0] STABLE_N = (CNT_W+1)'(STABLE_SAMPLES);
   localparam logic [CNT_W:0] HOLD_N   = (CNT_W+1)'(HOLD_SAMPLES);

   logic strobe;
   logic key_sync;
   logic k;

   sync_edge_detect #(.EDGE(1'b1)) u_sample_sync (
      .clk (clk),
      .rst (rst),
      .d_i (sample_clk),
      .q_o (strobe)
   );

   sync_edge_detect #(.EDGE(1'b0)) u_key_sync (
      .clk (clk),
      .rst (rst),
      .d_i (key_raw),
      .q_o (key_sync)
   );

   // Polarity fix-up after the synchroniser so both polarities see the
   // same metastability path.
   assign k = key_sync ^ ACTIVE_LOW;

   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             from_held_q, from_held_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             level_q, level_d;
   logic             hold_q, hold_d;

   logic [CNT_W:0]   cnt_inc;
   logic [CNT_W-1:0] cnt_sat;
   logic             stable_hit;
   logic             hold_hit;

   assign cnt_inc    = {1'b0, cnt_q} + 1'b1;
   assign cnt_sat    = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[CNT_W-1:0];
   assign stable_hit = (cnt_inc == STABLE_N);
   assign hold_hit   = (cnt_inc == HOLD_N);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      from_held_d = from_held_q;
      press_d     = 1'b0;
      release_d   = 1'b0;

      if (strobe) begin
         cnt_d = cnt_sat;
         unique case (state_q)
            IDLE: begin
               if (k) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = 8'd1;
               end
            end
            PRESS_WAIT: begin
               if (!k) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (stable_hit) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  press_d = 1'b1;
               end
            end
            PRESSED: begin
               if (!k) begin
                  state_d     = RELEASE_WAIT;
                  cnt_d       = 8'd1;
                  from_held_d = 1'b0;
               end else if (hold_hit) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end
            end
            HELD: begin
               if (!k) begin
                  state_d     = RELEASE_WAIT;
                  cnt_d       = 8'd1;
                  from_held_d = 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (k) begin
                  // Bounce-back: resume where we were; the counter is
                  // deliberately left as-is rather than cleared.
                  state_d = from_held_q ? HELD : PRESSED;
                  cnt_d   = cnt_q;
               end else if (stable_hit) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  release_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // Level/hold are registered from the next state so they move in the
      // same cycle as the press/release pulses.
      level_d = (state_d == PRESSED) || (state_d == HELD) ||
                (state_d == RELEASE_WAIT);
      hold_d  = (state_d == HELD) ||
                ((state_d == RELEASE_WAIT) && from_held_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         from_held_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         level_q     <= 1'b0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         from_held_q <= from_held_d;
         press_q     <= press_d;
         release_q   <= release_d;
         level_q     <= level_d;
         hold_q      <= hold_d;
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_hold    = hold_q;

endmodule

// File: tb/tb_jump_key_debounce.sv
// tb_jump_key_debounce
//   Drives an active-high and an active-low instance with complementary
//   key inputs, so both must produce identical responses. A sample-level
//   reference model predicts every change of {press,release,level,hold}
//   and queues it; a monitor pops and compares on every observed change.
module tb_jump_key_debounce;

   localparam int STABLE = 4;
   localparam int HOLD   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sample_clk = 1'b0;
   logic key_raw = 1'b0;
   logic key_raw_n;
   logic sclk_run = 1'b0;
   int   div = 0;

   logic [1:0] lvl, prs, rel, hld;

   assign key_raw_n = ~key_raw;

   jump_key_debounce #(
      .STABLE_SAMPLES(STABLE), .HOLD_SAMPLES(HOLD), .ACTIVE_LOW(1'b0)
   ) dut_hi (
      .clk(clk), .rst(rst), .sample_clk(sample_clk), .key_raw(key_raw),
      .key_level(lvl[0]), .key_press(prs[0]), .key_release(rel[0]),
      .key_hold(hld[0])
   );

   jump_key_debounce #(
      .STABLE_SAMPLES(STABLE), .HOLD_SAMPLES(HOLD), .ACTIVE_LOW(1'b1)
   ) dut_lo (
      .clk(clk), .rst(rst), .sample_clk(sample_clk), .key_raw(key_raw_n),
      .key_level(lvl[1]), .key_press(prs[1]), .key_release(rel[1]),
      .key_hold(hld[1])
   );

   always #5 clk = ~clk;

   // sample_clk toggles every 5 clk cycles while running (strobe every 10)
   always @(negedge clk) begin
      if (sclk_run) begin
         if (div == 4) begin
            div = 0;
            sample_clk = ~sample_clk;
         end else begin
            div++;
         end
      end
   end

   typedef struct {
      int         cyc;
      logic [3:0] o;     // {press, release, level, hold}
   } ev_t;

   ev_t q0[$];
   ev_t q1[$];

   int ncmp  = 0;
   int nfail = 0;
   int cyc   = 0;

   // ---------------- reference model ----------------
   bit m_ss1, m_ss2, m_sp, m_ks1, m_ks2;
   bit m_lvl, m_hold, m_prs, m_rel;
   int run, hc;          // run: consecutive samples disagreeing with level
   logic [3:0] m_last = 4'b0;

   task automatic model_sample(input bit k);
      if (!m_lvl) begin
         if (k) begin
            run++;
            if (run == STABLE) begin
               m_lvl = 1'b1; m_prs = 1'b1; run = 0; hc = 0;
            end
         end else begin
            run = 0;
         end
      end else begin
         if (!k) begin
            run++;
            if (run == STABLE) begin
               m_lvl = 1'b0; m_hold = 1'b0; m_rel = 1'b1; run = 0;
            end
         end else if (run > 0) begin
            // bounce-back: hold count resumes from the release-wait count
            hc  = run;
            run = 0;
         end else if (!m_hold) begin
            hc++;
            if (hc == HOLD) m_hold = 1'b1;
         end
      end
   endtask

   always @(posedge clk) begin
      bit strobe;
      logic [3:0] cur;
      cyc++;
      m_prs = 1'b0;
      m_rel = 1'b0;
      if (rst) begin
         m_ss1 = 0; m_ss2 = 0; m_sp = 0; m_ks1 = 0; m_ks2 = 0;
         m_lvl = 0; m_hold = 0; run = 0; hc = 0;
      end else begin
         strobe = m_ss2 && !m_sp;
         if (strobe) model_sample(m_ks2);
         m_sp  = m_ss2;
         m_ss2 = m_ss1;
         m_ss1 = sample_clk;
         m_ks2 = m_ks1;
         m_ks1 = key_raw;
      end
      cur = {m_prs, m_rel, m_lvl, m_hold};
      if (cur != m_last) begin
         q0.push_back('{cyc: cyc, o: cur});
         q1.push_back('{cyc: cyc, o: cur});
         m_last = cur;
      end
   end

   // ---------------- monitor ----------------
   logic [3:0] mon_last [2] = '{4'b0, 4'b0};

   always @(negedge clk) begin
      logic [3:0] cur;
      ev_t e;
      int  qs;
      for (int i = 0; i < 2; i++) begin
         cur = {prs[i], rel[i], lvl[i], hld[i]};
         if (cur !== mon_last[i]) begin
            ncmp++;
            qs = (i == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
               nfail++;
               $display("FAIL unexpected_change dut%0d cyc=%0d got=%b required=%b",
                        i, cyc, cur, mon_last[i]);
            end else begin
               if (i == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               if (e.cyc != cyc || e.o !== cur) begin
                  nfail++;
                  $display("FAIL event dut%0d got=%b@%0d required=%b@%0d",
                           i, cur, cyc, e.o, e.cyc);
               end
            end
            mon_last[i] = cur;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic hold_key(input bit v, input int n);
      key_raw = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_idle(input string name);
      for (int i = 0; i < 2; i++) begin
         ncmp++;
         if ({prs[i], rel[i], lvl[i], hld[i]} !== 4'b0) begin
            nfail++;
            $display("FAIL %s dut%0d got=%b required=0000", name, i,
                     {prs[i], rel[i], lvl[i], hld[i]});
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle("reset_state");
      rst = 1'b0;
      sclk_run = 1'b1;
      hold_key(0, 40);

      // clean press, then release
      hold_key(1, 200);
      hold_key(0, 100);

      // bouncing press settling high
      for (int i = 0; i < 20; i++) hold_key(i[0] ? 1'b0 : 1'b1, 3);
      hold_key(1, 150);
      hold_key(0, 100);

      // short glitch
      hold_key(1, 25);
      hold_key(0, 100);
      check_idle("glitch_rejected");

      // long hold into HELD, then release
      hold_key(1, 300);
      hold_key(0, 100);

      // reset mid press-wait
      hold_key(1, 25);
      rst = 1'b1;
      @(negedge clk);
      check_idle("reset_mid_debounce");
      rst = 1'b0;
      hold_key(1, 150);
      hold_key(0, 100);

      // release bounce-back from PRESSED
      hold_key(1, 80);
      hold_key(0, 20);
      hold_key(1, 200);
      hold_key(0, 100);

      // sample_clk frozen: no strobes, nothing may change
      sclk_run = 1'b0;
      for (int i = 0; i < 15; i++) hold_key(1'($urandom_range(0, 1)), 10);
      hold_key(0, 10);
      sclk_run = 1'b1;
      hold_key(0, 100);

      // randomized segments
      for (int i = 0; i < 30; i++)
         hold_key(1'($urandom_range(0, 1)), $urandom_range(3, 90));

      hold_key(0, 200);
      check_idle("final_idle");

      ncmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         nfail++;
         $display("FAIL missing_events got=%0d/%0d pending required=0",
                  q0.size(), q1.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
